muldiv_unit: RTL

//  Multi-cycle multiply/divide unit for MULT/MULTU/DIV/DIVU, with HI/LO result registers.
//  It is the sequential counterpart of the single-cycle ALU: the datapath issues an op with a

---
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one iteration per clock, on
// operand magnitudes; signs are restored in a single FIX cycle.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] portA,
   input  logic [WIDTH-1:0] portB,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t             state_reg, state_next;
   logic [CNTW-1:0]    cnt_reg;
   logic               is_div_reg;
   logic               neg_res_reg;   // negate product (MUL) or quotient (DIV)
   logic               neg_rem_reg;   // remainder takes the dividend's sign
   logic [WIDTH-1:0]   opnd_reg;      // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_reg;       // {hi,lo} product or {rem,quot}
   logic [WIDTH-1:0]   hi_reg, lo_reg;
   logic               divzero_reg;

   // Operand decode at the accept point
   logic               accept, signed_op, div_op, a_neg, b_neg, dz;
   logic [WIDTH-1:0]   a_mag, b_mag;

   // Decode the incoming request and take operand magnitudes
   always_comb begin
      accept    = start && (state_reg == S_IDLE || state_reg == S_DONE);
      signed_op = ~op[0];
      div_op    = op[1];
      a_neg     = signed_op & portA[WIDTH-1];
      b_neg     = signed_op & portB[WIDTH-1];
      a_mag     = a_neg ? ('0 - portA) : portA;
      b_mag     = b_neg ? ('0 - portB) : portB;
      dz        = div_op && (portB == '0);
   end

   // Next-state logic and status outputs
   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (accept) state_next = dz ? S_DONE : S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (cnt_reg == CNTW'(WIDTH-1)) state_next = S_FIX;
         end
         S_FIX: begin
            busy       = 1'b1;
            state_next = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (accept) state_next = dz ? S_DONE : S_RUN;
            else        state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // One iteration of shift-add multiply or restoring divide
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_shift;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] acc_next;

   always_comb begin
      mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
      mul_next  = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                             : {1'b0, acc_reg[2*WIDTH-1:1]};
      div_shift = {acc_reg[2*WIDTH-2:0], 1'b0};
      // Bit shifted out of rem is kept so the trial compare stays exact
      div_trial = {acc_reg[2*WIDTH-1], div_shift[2*WIDTH-1:WIDTH]} - {1'b0, opnd_reg};
      div_next  = div_trial[WIDTH] ? div_shift
                                   : {div_trial[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
      acc_next  = is_div_reg ? div_next : mul_next;
   end

   // Sign restoration applied in FIX
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   always_comb begin
      prod_fix = neg_res_reg ? ('0 - acc_reg) : acc_reg;
      quot_fix = neg_res_reg ? ('0 - acc_reg[WIDTH-1:0]) : acc_reg[WIDTH-1:0];
      rem_fix  = neg_rem_reg ? ('0 - acc_reg[2*WIDTH-1:WIDTH]) : acc_reg[2*WIDTH-1:WIDTH];
   end

   // State register, work registers and HI/LO updates
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         is_div_reg  <= 1'b0;
         neg_res_reg <= 1'b0;
         neg_rem_reg <= 1'b0;
         opnd_reg    <= '0;
         acc_reg     <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         divzero_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            cnt_reg     <= '0;
            is_div_reg  <= div_op;
            divzero_reg <= dz;
            neg_res_reg <= a_neg ^ b_neg;
            neg_rem_reg <= div_op & a_neg;
            opnd_reg    <= div_op ? b_mag : a_mag;
            acc_reg     <= div_op ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
         end else if (state_reg == S_RUN) begin
            cnt_reg <= cnt_reg + 1'b1;
            acc_reg <= acc_next;
         end
         if (state_reg == S_FIX) begin
            if (is_div_reg) begin
               hi_reg <= rem_fix;
               lo_reg <= quot_fix;
            end else begin
               hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
               lo_reg <= prod_fix[WIDTH-1:0];
            end
         end
         // MTHI/MTLO only while not busy; FIX never coincides with this
         if (!busy && hi_we) hi_reg <= wdata;
         if (!busy && lo_we) lo_reg <= wdata;
      end
   end

   assign hi      = hi_reg;
   assign lo      = lo_reg;
   assign divzero = divzero_reg;

endmodule
